// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel registered mux/arbiter.
// Mode encodings and the packet-lock FSM state type live here so the top
// level and any future siblings agree on them.
package mux_pkg;

    // Selection mode, driven on the 'mode' input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Packet-lock FSM (used only when MUX_PKT_LOCK_EN is defined).
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin priority picker.
// Scans req starting at ptr+1 and wrapping modulo N; the first set bit wins.
// ptr itself is scanned last, so a lone requester at ptr is still granted.
module rr_grant #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    // Wrap-around priority scan; earlier positions after ptr take precedence.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N-channel registered mux with valid/ready handshakes.
// mode=0 picks the channel named by sel, mode=1 arbitrates round-robin.
// One output register; a word drained and a new word loaded in the same
// cycle keeps the output at full throughput.
// Optional: define MUX_PKT_LOCK_EN to add in_last/out_last and hold the
// grant on one channel until its packet ends.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef MUX_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic                  load_en;
    logic                  xfer;
    logic [SEL_W-1:0]      ptr;
    logic                  rr_valid;
    logic [SEL_W-1:0]      rr_idx;
    logic [SEL_SPAN-1:0]   valid_ext;
    logic                  gnt_valid;
    logic [SEL_W-1:0]      gnt_idx;
    logic [WIDTH-1:0]      ch_data [N];

`ifdef MUX_PKT_LOCK_EN
    lock_state_t           state_q, state_d;
    logic [SEL_W-1:0]      lock_ch_q, lock_ch_d;
`endif

    // The output register can take a word when empty or being drained now.
    assign load_en = !out_valid || out_ready;

    rr_grant #(.N(N)) u_rr_grant (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Grant selection: fixed/rr by mode, overridden by an active packet lock.
    // valid_ext zero-pads in_valid so an out-of-range sel reads a 0.
    always_comb begin
        valid_ext           = '0;
        valid_ext[N-1:0]    = in_valid;
        if (mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = valid_ext[sel];
            gnt_idx   = sel;
        end
`ifdef MUX_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            gnt_valid = in_valid[lock_ch_q];
            gnt_idx   = lock_ch_q;
        end
`endif
    end

    // Per-channel data slicing and one-hot ready generation.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign ch_data[i]  = in_data[i*WIDTH +: WIDTH];
        assign in_ready[i] = rst_n && load_en && gnt_valid &&
                             (gnt_idx == SEL_W'(i));
    end

    // A granted channel is valid by construction, so grant + room = transfer.
    assign xfer = rst_n && load_en && gnt_valid;

    // Output register: load on transfer, otherwise empty when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[gnt_idx];
            out_sel   <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer: the last rr winner becomes lowest priority.
    // Reset to N-1 so channel 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SEL_W'(N - 1);
        end else if (xfer && (mode == MODE_RR)) begin
            ptr <= gnt_idx;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    // Lock FSM state and locked channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Lock FSM next state: a non-last word locks, the locked channel's last word frees.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            IDLE: begin
                if (xfer && !in_last[gnt_idx]) begin
                    state_d   = LOCKED;
                    lock_ch_d = gnt_idx;
                end
            end
            LOCKED: begin
                if (xfer && in_last[lock_ch_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // End-of-packet flag travels with the registered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last <= 1'b0;
        end else if (xfer) begin
            out_last <= in_last[gnt_idx];
        end
    end
`endif

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Parametrised successor to the team's 4:1 gate-level mux: N channels of WIDTH bits, each with a valid/ready handshake.
- Selection is either fixed by a `sel` input or round-robin across all requesting channels.
- The output is registered: one output stage holding one word.
- Sits between multiple producers (sensor/UART/FIFO sources) and a single downstream consumer.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- SEL_W, $clog2(N), width of the channel index; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select by sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready (combinational).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority after reset.
  - in_ready=0 while reset is asserted.
- load_en = !out_valid || out_ready.
- Grant (combinational):
  - mode=0: grant=sel if sel<N and in_valid[sel]; otherwise no grant.
  - mode=1: grant = first i with in_valid[i], scanning ptr+1, ptr+2, ... modulo N; no grant if in_valid==0.
- in_ready[i] = load_en && grant valid && grant==i. All other in_ready bits are 0, so at most one bit is high.
- Transfer on channel i (in_valid[i] && in_ready[i]) at a rising edge:
  - out_data<=in_data[i], out_sel<=i, out_valid<=1.
  - In mode=1, ptr<=i.
- Output handshake:
  - out_valid && out_ready with no new transfer: out_valid<=0.
  - Simultaneous output drain and new load: register is reloaded and out_valid stays 1, giving full throughput (1 word/cycle).
- Latency: exactly 1 cycle from the input handshake to out_valid.
- out_valid=1 && out_ready=0: out_data and out_sel stay stable; no input is accepted.
- ptr changes only on a transfer in mode=1. A mode switch takes effect next cycle and does not reset ptr.
- ptr wrap: ptr=N-1 scans from 0.
- sel>=N (possible when N is not a power of 2): no grant, no transfer.
- Reset mid-transfer discards the held word. No partial state survives.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- With the macro defined:
  - Extra input in_last [N] (end of packet per channel).
  - Two-state FSM: IDLE and LOCKED.
  - IDLE → LOCKED on a transfer with in_last[i]=0; lock_ch<=i.
  - While LOCKED, grant=lock_ch only if in_valid[lock_ch]; all other channels and sel are ignored.
  - LOCKED → IDLE on a transfer from lock_ch with in_last=1.
  - Extra output out_last is registered alongside out_data.
  - Reset → IDLE.
- Without the macro: no in_last/out_last ports, no FSM, and arbitration is per word.

Decomposition:
- Shared package mux_pkg:
  - Mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Lock-FSM state typedef (IDLE, LOCKED).
- Sub-module rr_grant: combinational round-robin priority picker. Inputs: req[N], ptr[SEL_W]. Outputs: gnt_valid, gnt_idx. This keeps the wrap-around scan separately testable.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_sel=0 immediately; in_ready=0.
- Fixed mode:
  - Setup: mode=0, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1.
  - Required: in_ready=4'b0100; next cycle out_data=8'hA5, out_sel=2; one word per cycle.
- Round-robin fairness:
  - Setup: mode=1, in_valid=4'b1011 held, out_ready=1.
  - Required: out_sel sequence 0,1,3,0,1,3; channel 2 is never granted.
- Backpressure:
  - Setup: out_ready=0 for 3 cycles after a load of 8'h3C.
  - Required: out_data stays 8'h3C; in_ready=0 throughout; the next word loads on the cycle out_ready=1.
- Simultaneous drain/load: out_valid=1, out_ready=1, in_valid[1]=1 → no bubble; out_valid stays 1 and out_sel=1 next cycle.
- MUX_PKT_LOCK_EN build:
  - Setup: mode=1; ch0 sends a 3-word packet (in_last on word 3) while ch1 is valid.
  - Required: out_sel=0,0,0 then 1; the FSM returns to IDLE after word 3.
